apb_led_bridge: RTL

APB_LED_BRIDGE -- requirements
Module: apb_led_bridge

---
 rtl/apb_led_bridge.sv | 123 ++++++++++++
 1 files changed

// File: rtl/apb_led_bridge.sv
// APB slave bridging to an 8-bit LED register block: access phase = WAIT_STATES+2 cycles,
// pready held low during the wait count; psel drop in WAIT aborts with no register write.
module apb_led_bridge #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [1:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    input  logic [7:0]  reg_rdata
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] addr;
        logic       write;
        logic [7:0] wdata;
    } req_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    req_t        req_q;
    logic [31:0] prdata_q;
    logic        setup;
    logic        err;
    logic [7:0]  rd_byte;
    logic        unused_pwdata;

    assign unused_pwdata = ^pwdata[31:8];

    assign setup = psel & ~penable;

    // Misaligned accesses fail; the reserved slot is read-as-zero but not writable.
    assign err     = (req_q.addr[1:0] != 2'd0) ||
                     (req_q.write && (req_q.addr[3:2] == 2'd3));
    assign rd_byte = (req_q.addr[3:2] == 2'd3) ? 8'd0 : reg_rdata;

    assign reg_addr  = req_q.addr[3:2];
    assign reg_wdata = req_q.wdata;
    assign prdata    = prdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        reg_we  = 1'b0;
        if (state_q == S_DONE) begin
            pready  = 1'b1;
            pslverr = err;
            reg_we  = req_q.write & ~err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            req_q <= '0;
        end else if ((state_q == S_IDLE) && setup) begin
            cnt_q <= WS_INIT;
            req_q <= '{addr: paddr, write: pwrite, wdata: pwdata[7:0]};
        end else if ((state_q == S_WAIT) && psel && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Read data is captured as DONE is entered and held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata_q <= 32'd0;
        end else if ((state_q == S_WAIT) && (state_d == S_DONE)) begin
            prdata_q <= (!req_q.write && !err) ? {24'd0, rd_byte} : 32'd0;
        end
    end

endmodule
